// File: rtl/traffic_phase_timer.sv
// Dwell timer in front of the traffic_lights sequencer: times each lamp phase,
// pulses step to advance it, shortens green on pedestrian demand, flags faults.
module traffic_phase_timer #(
  parameter int CNT_W           = 16,
  parameter int RED_TICKS       = 20,
  parameter int RED_AMBER_TICKS = 4,
  parameter int GREEN_TICKS     = 20,
  parameter int AMBER_TICKS     = 6,
  parameter int MIN_GREEN       = 5,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             ped_req,
  output logic             step,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_pending,
  output logic             fault
);

  typedef enum logic [1:0] {LOAD, COUNT, STEP, WAIT} state_t;
  typedef enum logic [2:0] {PH_RED, PH_RED_AMBER, PH_GREEN, PH_AMBER, PH_INVALID} phase_t;

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  localparam logic [CNT_W-1:0] RED_LOAD       = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_AMBER_LOAD = CNT_W'(RED_AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD     = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] AMBER_LOAD     = CNT_W'(AMBER_TICKS - 1);
  // Green may end early once the count has fallen to this level with a request pending.
  localparam logic [CNT_W-1:0] PED_THR        = CNT_W'(GREEN_TICKS - MIN_GREEN);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  if (RED_TICKS < 1 || RED_AMBER_TICKS < 1 || GREEN_TICKS < 1 || AMBER_TICKS < 1 ||
      longint'(RED_TICKS - 1) >= CNT_SPAN || longint'(RED_AMBER_TICKS - 1) >= CNT_SPAN ||
      longint'(GREEN_TICKS - 1) >= CNT_SPAN || longint'(AMBER_TICKS - 1) >= CNT_SPAN)
  begin : g_bad_ticks
    $error("traffic_phase_timer: phase tick count out of range for CNT_W");
  end

  if (MIN_GREEN < 1 || MIN_GREEN > GREEN_TICKS || ACK_TIMEOUT < 1) begin : g_bad_limits
    $error("traffic_phase_timer: MIN_GREEN or ACK_TIMEOUT out of range");
  end

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d, live_phase;
  logic [CNT_W-1:0]   rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               step_d, ped_d, fault_d;
  logic [CNT_W-1:0]   load_val;

  always_comb begin
    case ({red, amber, green})
      3'b100:  live_phase = PH_RED;
      3'b110:  live_phase = PH_RED_AMBER;
      3'b001:  live_phase = PH_GREEN;
      3'b010:  live_phase = PH_AMBER;
      default: live_phase = PH_INVALID;
    endcase
  end

  always_comb begin
    case (live_phase)
      PH_RED:       load_val = RED_LOAD;
      PH_RED_AMBER: load_val = RED_AMBER_LOAD;
      PH_GREEN:     load_val = GREEN_LOAD;
      PH_AMBER:     load_val = AMBER_LOAD;
      default:      load_val = '0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = remaining;
    wait_d  = wait_q;
    fault_d = fault;

    case (state_q)
      LOAD: begin
        phase_d = live_phase;
        if (live_phase == PH_INVALID) begin
          fault_d = 1'b1;
          rem_d   = '0;
          state_d = STEP;
        end else begin
          rem_d   = load_val;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (live_phase != phase_q) begin
          fault_d = 1'b1;
          state_d = LOAD;
        end else if (en) begin
          if (remaining == '0 ||
              (phase_q == PH_GREEN && ped_pending && remaining <= PED_THR)) begin
            state_d = STEP;
          end else begin
            rem_d = remaining - 1'b1;
          end
        end
      end
      STEP: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (live_phase != phase_q) begin
          state_d = LOAD;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            fault_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    step_d = (state_d == STEP);

    // A request in the same cycle as the red reload wins over the clear.
    if (ped_req)
      ped_d = 1'b1;
    else if (state_q == LOAD && live_phase == PH_RED)
      ped_d = 1'b0;
    else
      ped_d = ped_pending;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      phase_q     <= PH_RED;
      remaining   <= '0;
      wait_q      <= '0;
      step        <= 1'b0;
      ped_pending <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining   <= rem_d;
      wait_q      <= wait_d;
      step        <= step_d;
      ped_pending <= ped_d;
      fault       <= fault_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with a sequencer model that advances
// the lamps one cycle after each step pulse.
module tb_traffic_phase_timer;

  logic        clk = 1'b0;
  logic        rst_n, en, red, amber, green, ped_req;
  logic        step, ped_pending, fault;
  logic [15:0] remaining;

  bit follow;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .CNT_W(16), .RED_TICKS(3), .RED_AMBER_TICKS(2), .GREEN_TICKS(5),
    .AMBER_TICKS(2), .MIN_GREEN(2), .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .red(red), .amber(amber), .green(green),
    .ped_req(ped_req), .step(step), .remaining(remaining),
    .ped_pending(ped_pending), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance();
    case ({red, amber, green})
      3'b100:  {red, amber, green} = 3'b110;
      3'b110:  {red, amber, green} = 3'b001;
      3'b001:  {red, amber, green} = 3'b010;
      default: {red, amber, green} = 3'b100;
    endcase
  endtask

  // One clock; the sequencer model reacts to a step that was high at this edge.
  task automatic tick();
    logic s;
    s = step;
    @(posedge clk);
    #1;
    if (s && follow) advance();
  endtask

  task automatic wait_step(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < max);
  endtask

  initial begin
    int n, total;
    bit saw_step;

    rst_n = 1'b0; en = 1'b1; ped_req = 1'b0; follow = 1'b1;
    {red, amber, green} = 3'b100;
    #2;
    check("reset_step", step, 0);
    check("reset_remaining", remaining, 0);
    check("reset_ped", ped_pending, 0);
    check("reset_fault", fault, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Normal cycle: red, red+amber, green, amber, red.
    wait_step(40, n);
    check("first_red_spacing", n, 4);
    check("first_red_colour", {red, amber, green}, 3'b100);
    check("first_red_remaining", remaining, 0);
    wait_step(40, n); total = n;
    check("ra_spacing", n, 5);
    check("ra_colour", {red, amber, green}, 3'b110);
    wait_step(40, n); total += n;
    check("green_spacing", n, 8);
    check("green_colour", {red, amber, green}, 3'b001);
    wait_step(40, n); total += n;
    check("amber_spacing", n, 5);
    check("amber_colour", {red, amber, green}, 3'b010);
    wait_step(40, n); total += n;
    check("red_spacing", n, 6);
    check("red_colour", {red, amber, green}, 3'b100);
    check("full_cycle", total, 24);
    check("no_fault", fault, 0);

    // Pedestrian pulse in the first green COUNT cycle.
    wait_step(40, n);
    check("ra_spacing2", n, 5);
    tick(); tick(); tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("ped_latched", ped_pending, 1);
    wait_step(40, n);
    check("ped_green_spacing", n + 4, 5);
    wait_step(40, n);
    check("ped_amber_spacing", n, 5);
    check("ped_held_amber", ped_pending, 1);
    tick(); tick();
    check("ped_before_red_load", ped_pending, 1);
    tick();
    check("ped_cleared_red_load", ped_pending, 0);
    wait_step(40, n);
    check("red_spacing2", n + 3, 6);

    // Late request (after MIN_GREEN elapsed) ends green on the next COUNT cycle.
    wait_step(40, n);
    check("ra_spacing3", n, 5);
    repeat (5) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    wait_step(40, n);
    check("late_ped_green_spacing", n + 6, 7);
    wait_step(40, n);
    check("amber_spacing3", n, 5);
    tick(); tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("ped_set_wins", ped_pending, 1);
    wait_step(40, n);
    check("red_spacing3", n + 3, 6);

    // Still-pending request shortens the following green.
    wait_step(40, n);
    check("ra_spacing4", n, 5);
    wait_step(40, n);
    check("pending_green_spacing", n, 5);
    wait_step(40, n);
    check("amber_spacing4", n, 5);

    // en low mid-red at remaining=1.
    repeat (4) tick();
    check("red_ped_cleared", ped_pending, 0);
    check("red_rem_before_hold", remaining, 1);
    en = 1'b0;
    saw_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step) saw_step = 1'b1;
    end
    check("hold_remaining", remaining, 1);
    check("hold_no_step", saw_step, 0);
    en = 1'b1;
    wait_step(40, n);
    check("resume_spacing", n, 2);

    // Sequencer ignores step: acknowledge timeout.
    follow = 1'b0;
    repeat (4) tick();
    check("timeout_not_yet", fault, 0);
    tick();
    check("timeout_fault", fault, 1);
    wait_step(40, n);
    check("retime_spacing", n, 4);
    check("retime_colour", {red, amber, green}, 3'b100);
    follow = 1'b1;
    wait_step(40, n);
    check("ra_after_timeout", n, 5);
    tick(); tick(); tick();
    check("green_loaded", remaining, 4);
    check("fault_sticky", fault, 1);

    // Asynchronous reset mid-COUNT.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_step", step, 0);
    check("async_remaining", remaining, 0);
    check("async_ped", ped_pending, 0);
    check("async_fault", fault, 0);

    // Illegal code after reset.
    {red, amber, green} = 3'b111;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("invalid_step", step, 1);
    check("invalid_fault", fault, 1);
    check("invalid_remaining", remaining, 0);
    wait_step(40, n);
    check("recover_red_spacing", n, 6);
    check("recover_colour", {red, amber, green}, 3'b100);
    wait_step(40, n);
    check("recover_ra_spacing", n, 5);
    check("recover_fault_sticky", fault, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
